mux_8x1_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the 4-bit, 8:1 datapath mux between eight requesters.
- Drives the mux 3-bit select and a one-hot grant vector.
- Holds each grant for a bounded burst of beats under a valid/ready handshake to the downstream consumer.
- Sits directly in front of the mux select input; the mux itself stays a separate block.

---
 rtl/mux_8x1_rr_arbiter.sv | 102 ++++++++++
 tb/tb_mux_8x1_rr_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_8x1_rr_arbiter.sv
// Round-robin arbiter driving the select and one-hot grant of a shared 4-bit 8:1 mux.
// Each grant lasts up to MAX_BURST accepted beats or until its requester drops its request.
module mux_8x1_rr_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_i,
    input  logic       out_ready_i,
    output logic [7:0] gnt_o,
    output logic [2:0] sel_o,
    output logic       out_valid_o,
    output logic       busy_o
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e           state_q;
    logic [7:0]       gnt_q;
    logic [2:0]       sel_q;
    logic [2:0]       ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic       outValid;
    logic       beat;
    logic       lastBeat;
    logic       relGnt;
    logic       anyReq;
    logic [2:0] arbBase;
    logic [2:0] winner;
    logic       found;

    assign outValid = (state_q == GRANT) & req_i[sel_q];
    assign beat     = outValid & out_ready_i;
    assign lastBeat = (cnt_q == CNT_W'(MAX_BURST - 1));
    assign relGnt   = (state_q == GRANT) & (~req_i[sel_q] | (beat & lastBeat));
    assign anyReq   = |req_i;

    // On release the search starts just past the current owner, i.e. at the pointer value being written.
    assign arbBase  = (state_q == GRANT) ? sel_q + 3'd1 : ptr_q;

    always_comb begin
        winner = arbBase;
        found  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && req_i[arbBase + 3'(i)]) begin
                winner = arbBase + 3'(i);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 8'h00;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyReq) begin
                        state_q <= GRANT;
                        sel_q   <= winner;
                        gnt_q   <= 8'b1 << winner;
                        cnt_q   <= '0;
                    end
                end
                GRANT: begin
                    if (relGnt) begin
                        ptr_q <= sel_q + 3'd1;
                        if (anyReq) begin
                            sel_q <= winner;
                            gnt_q <= 8'b1 << winner;
                            cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= 8'h00;
                        end
                    end else if (beat) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 8'h00;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign sel_o       = sel_q;
    assign out_valid_o = outValid;
    assign busy_o      = (state_q == GRANT);

endmodule

// File: tb/tb_mux_8x1_rr_arbiter.sv
// Bench for mux_8x1_rr_arbiter: a per-cycle grant model plus directed scenarios and random traffic.
module tb_mux_8x1_rr_arbiter;

    localparam int MAX_BURST = 4;

    logic       clk = 1'b0;
    logic       rstN;
    logic [7:0] req;
    logic       outReady;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       outValid;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    bit mGranted = 1'b0;
    int mOwner   = 0;
    int mPtr     = 0;
    int mBeats   = 0;
    int mWin;
    bit mRel;

    mux_8x1_rr_arbiter #(
        .MAX_BURST(MAX_BURST),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .req_i      (req),
        .out_ready_i(outReady),
        .gnt_o      (gnt),
        .sel_o      (sel),
        .out_valid_o(outValid),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int pickWinner(input logic [7:0] r, input int base);
        int idx;
        for (int k = 0; k < 8; k++) begin
            idx = (base + k) % 8;
            if (r[idx[2:0]]) return idx;
        end
        return -1;
    endfunction

    // Model holds who owns the mux and how many beats it has moved; compared at every falling edge.
    always @(negedge clk or negedge rstN) begin
        if (!rstN) begin
            mGranted = 1'b0;
            mOwner   = 0;
            mPtr     = 0;
            mBeats   = 0;
        end else begin
            checkOutput("model_busy", busy, mGranted);
            checkOutput("model_valid", outValid, mGranted && req[mOwner[2:0]]);
            checkOutput("model_gnt", gnt, mGranted ? (1 << mOwner) : 0);
            if (mGranted) checkOutput("model_sel", sel, mOwner);
            if (!mGranted) begin
                mWin = pickWinner(req, mPtr);
                if (mWin >= 0) begin
                    mGranted = 1'b1;
                    mOwner   = mWin;
                    mBeats   = 0;
                end
            end else begin
                mRel = 1'b0;
                if (!req[mOwner[2:0]]) begin
                    mRel = 1'b1;
                end else if (outReady) begin
                    mBeats++;
                    if (mBeats == MAX_BURST) mRel = 1'b1;
                end
                if (mRel) begin
                    mPtr = (mOwner + 1) % 8;
                    mWin = pickWinner(req, mPtr);
                    if (mWin >= 0) begin
                        mOwner = mWin;
                        mBeats = 0;
                    end else begin
                        mGranted = 1'b0;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] r, input logic rdy);
        @(posedge clk);
        #1;
        req      = r;
        outReady = rdy;
        @(negedge clk);
    endtask

    task automatic resetDut(input logic [7:0] r, input logic rdy);
        @(posedge clk);
        #1;
        rstN     = 1'b0;
        req      = r;
        outReady = rdy;
        @(negedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(negedge clk);
    endtask

    logic [7:0] randReq;
    logic       randReady;

    initial begin
        rstN     = 1'b0;
        req      = 8'hFF;
        outReady = 1'b1;

        @(negedge clk);
        checkOutput("reset_gnt", gnt, 8'h00);
        checkOutput("reset_sel", sel, 0);
        checkOutput("reset_valid", outValid, 0);
        checkOutput("reset_busy", busy, 0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(negedge clk);
        applyStimulus(8'hFF, 1'b1);
        checkOutput("first_gnt", gnt, 8'h01);
        checkOutput("first_sel", sel, 0);

        resetDut(8'h20, 1'b1);
        applyStimulus(8'h20, 1'b1);
        checkOutput("sole_gnt", gnt, 8'h20);
        checkOutput("sole_sel", sel, 5);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'h20, 1'b1);
            checkOutput("sole_hold_gnt", gnt, 8'h20);
            checkOutput("sole_hold_valid", outValid, 1);
        end

        resetDut(8'hFF, 1'b1);
        for (int c = 0; c <= 32; c++) begin
            applyStimulus(8'hFF, 1'b1);
            checkOutput("rotation_sel", sel, (c / 4) % 8);
            checkOutput("rotation_busy", busy, 1);
        end

        resetDut(8'h08, 1'b0);
        applyStimulus(8'h08, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'h09, 1'b0);
            checkOutput("backpressure_gnt", gnt, 8'h08);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h09, 1'b1);
            checkOutput("burst_gnt", gnt, 8'h08);
            checkOutput("burst_valid", outValid, 1);
        end
        applyStimulus(8'h09, 1'b1);
        checkOutput("after_burst_gnt", gnt, 8'h01);

        resetDut(8'h44, 1'b1);
        applyStimulus(8'h44, 1'b1);
        checkOutput("withdraw_first_gnt", gnt, 8'h04);
        applyStimulus(8'h44, 1'b1);
        applyStimulus(8'h40, 1'b1);
        checkOutput("withdraw_valid", outValid, 0);
        applyStimulus(8'h40, 1'b1);
        checkOutput("withdraw_next_gnt", gnt, 8'h40);
        checkOutput("withdraw_next_sel", sel, 6);

        resetDut(8'h03, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h03, 1'b1);
        checkOutput("src1_gnt", gnt, 8'h02);
        applyStimulus(8'h03, 1'b1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_gnt", gnt, 8'h00);
        checkOutput("async_valid", outValid, 0);
        checkOutput("async_busy", busy, 0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(negedge clk);
        applyStimulus(8'h03, 1'b1);
        checkOutput("restart_gnt", gnt, 8'h01);

        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       randReq = 8'($urandom);
                    1:       randReq = 8'($urandom) & 8'($urandom) & 8'($urandom);
                    2:       randReq = 8'h00;
                    default: randReq = 8'h1 << $urandom_range(0, 7);
                endcase
            end
            randReady = ($urandom_range(0, 3) != 0);
            applyStimulus(randReq, randReady);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial randReq = 8'hA5;

endmodule
